bsg_arb_rr_hold: RTL and testbench

Registered round-robin arbiter that shares one downstream resource among `els_p` requesters. Its primary client is a narrow enable/reset register bank that can accept one writer per cycle. The block grants one requester at a time and lets the owner lock the grant across multi-beat transfers, subject to a bounded hold count. It also tracks the round-robin pointer so that no requester starves. `grants_o` drives the write-enable mux select; `yumi_i` is the resource's accept strobe.

---
 rtl/bsg_arb_rr_hold_if.sv | 25 ++
 rtl/bsg_arb_rr_hold.sv | 123 ++++++++++++
 tb/tb_bsg_arb_rr_hold.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bsg_arb_rr_hold_if.sv
// Request/grant bundle between requesters, the shared resource and the
// round-robin hold arbiter.
interface bsg_arb_rr_hold_if #(
    parameter int els_p = 3
);
    localparam int unsigned tag_w = $clog2(els_p);

    logic [els_p-1:0] reqs_i;
    logic [els_p-1:0] lock_i;
    logic             yumi_i;
    logic [els_p-1:0] grants_o;
    logic             v_o;
    logic [tag_w-1:0] tag_o;
    logic             hold_timeout_o;

    // master: requesters plus resource accept strobe; slave: the arbiter
    modport master (
        output reqs_i, lock_i, yumi_i,
        input  grants_o, v_o, tag_o, hold_timeout_o
    );
    modport slave (
        input  reqs_i, lock_i, yumi_i,
        output grants_o, v_o, tag_o, hold_timeout_o
    );
endinterface

// File: rtl/bsg_arb_rr_hold.sv
// Registered round-robin arbiter with bounded grant locking for multi-beat
// transfers; the released owner drops to lowest priority.
module bsg_arb_rr_hold #(
    parameter int els_p      = 3,
    parameter int hold_max_p = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bsg_arb_rr_hold_if.slave bus
);
    localparam int unsigned tag_w = $clog2(els_p);
    localparam int unsigned cnt_w = $clog2(hold_max_p + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e           state_r, state_n;
    logic [tag_w-1:0] owner_r, owner_n;
    logic [tag_w-1:0] last_r, last_n;
    logic [cnt_w-1:0] hold_cnt_r, hold_cnt_n;
    logic             timeout_n;
    logic [els_p-1:0] grants_n;
    logic [tag_w-1:0] tag_n;
    logic             v_n;
    logic [tag_w-1:0] pick_base;
    logic [tag_w-1:0] pick_idx;

    // First set bit of v strictly after base, wrapping modulo els_p.
    function automatic logic [tag_w-1:0] pick(input logic [els_p-1:0] v,
                                              input logic [tag_w-1:0] base);
        logic [tag_w-1:0] res;
        logic             found;
        int               idx;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= els_p; i++) begin
            idx = int'(base) + i;
            if (idx >= els_p) idx = idx - els_p;
            if (!found && v[idx]) begin
                res   = tag_w'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // In BUSY a pick only happens on release, where the owner becomes last.
    assign pick_base = (state_r == BUSY) ? owner_r : last_r;
    assign pick_idx  = pick(bus.reqs_i, pick_base);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r            <= IDLE;
            owner_r            <= '0;
            last_r             <= tag_w'(els_p - 1);
            hold_cnt_r         <= '0;
            bus.hold_timeout_o <= 1'b0;
            bus.grants_o       <= '0;
            bus.v_o            <= 1'b0;
            bus.tag_o          <= '0;
        end else begin
            state_r            <= state_n;
            owner_r            <= owner_n;
            last_r             <= last_n;
            hold_cnt_r         <= hold_cnt_n;
            bus.hold_timeout_o <= timeout_n;
            bus.grants_o       <= grants_n;
            bus.v_o            <= v_n;
            bus.tag_o          <= tag_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        owner_n    = owner_r;
        last_n     = last_r;
        hold_cnt_n = hold_cnt_r;
        timeout_n  = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (|bus.reqs_i) begin
                    owner_n    = pick_idx;
                    hold_cnt_n = '0;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                if (!bus.yumi_i) begin
                    // Retract drops to IDLE; stall keeps everything.
                    if (!bus.reqs_i[owner_r]) begin
                        state_n    = IDLE;
                        hold_cnt_n = '0;
                    end
                end else if (bus.lock_i[owner_r] && bus.reqs_i[owner_r]
                             && (int'(hold_cnt_r) < hold_max_p - 1)) begin
                    hold_cnt_n = hold_cnt_r + cnt_w'(1);
                end else begin
                    last_n     = owner_r;
                    hold_cnt_n = '0;
                    timeout_n  = bus.lock_i[owner_r] && bus.reqs_i[owner_r];
                    if (|bus.reqs_i) owner_n = pick_idx;
                    else             state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant outputs are decoded from next state and then registered.
    always_comb begin
        grants_n = '0;
        tag_n    = '0;
        v_n      = 1'b0;
        if (state_n == BUSY) begin
            grants_n = els_p'(1) << owner_n;
            tag_n    = owner_n;
            v_n      = 1'b1;
        end
    end

    idle_yumi_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                  !(state_r == IDLE && bus.yumi_i));

endmodule

// File: tb/tb_bsg_arb_rr_hold.sv
// Directed bench for bsg_arb_rr_hold (els_p=3, hold_max_p=4): vector table
// plus a hand-written asynchronous reset sequence.
module tb_bsg_arb_rr_hold;
    localparam int els_c  = 3;
    localparam int hold_c = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    logic yumi_en = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [2:0] reqs;
        logic [2:0] lock;
        logic       yumi;
        logic [2:0] grants;
        logic [1:0] tag;
        logic       v;
        logic       to;
        string      name;
    } vec_t;

    vec_t vecs[$];

    bsg_arb_rr_hold_if #(.els_p(els_c)) bus ();

    bsg_arb_rr_hold #(.els_p(els_c), .hold_max_p(hold_c)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // The resource only accepts a transfer that is actually granted.
    assign bus.yumi_i = yumi_en & bus.v_o;

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input string n, input logic [2:0] r, input logic [2:0] l,
                                input logic y, input logic [2:0] g, input logic [1:0] t,
                                input logic to);
        vec_t x;
        x.name = n; x.reqs = r; x.lock = l; x.yumi = y;
        x.grants = g; x.tag = t; x.v = |g; x.to = to;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] g, input logic [1:0] t,
                           input logic v, input logic to);
        chk({name, ".grants"}, 32'(bus.grants_o), 32'(g));
        chk({name, ".tag"}, 32'(bus.tag_o), 32'(t));
        chk({name, ".v"}, 32'(bus.v_o), 32'(v));
        chk({name, ".timeout"}, 32'(bus.hold_timeout_o), 32'(to));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rotation under full load
        vecs.push_back(mk("rot0", 3'b111, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("rot1", 3'b111, 3'b000, 1'b1, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("rot2", 3'b111, 3'b000, 1'b1, 3'b100, 2'd2, 1'b0));
        vecs.push_back(mk("rot3", 3'b111, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("rot4", 3'b111, 3'b000, 1'b1, 3'b010, 2'd1, 1'b0));
        // stall then retract then re-arbitrate from last=0
        vecs.push_back(mk("stall0", 3'b010, 3'b000, 1'b0, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("stall1", 3'b010, 3'b000, 1'b0, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("stall2", 3'b010, 3'b000, 1'b0, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("retract", 3'b000, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0));
        vecs.push_back(mk("regrant", 3'b111, 3'b000, 1'b0, 3'b010, 2'd1, 1'b0));
        // lock limit: owner 0 holds 4 cycles, then forced rotation
        vecs.push_back(mk("lock0", 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("lock1", 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("lock2", 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("lock3", 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0));
        vecs.push_back(mk("lock_to", 3'b011, 3'b001, 1'b1, 3'b010, 2'd1, 1'b1));
        vecs.push_back(mk("lock_after", 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0));
        // non-owner lock ignored until it owns, then it holds 4
        vecs.push_back(mk("nolock0", 3'b011, 3'b010, 1'b1, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("nolock1", 3'b011, 3'b010, 1'b1, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("nolock2", 3'b011, 3'b010, 1'b1, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("nolock3", 3'b011, 3'b010, 1'b1, 3'b010, 2'd1, 1'b0));
        vecs.push_back(mk("nolock_to", 3'b011, 3'b010, 1'b1, 3'b001, 2'd0, 1'b1));
        // single requester, no bubbles
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk($sformatf("single%0d", i), 3'b100, 3'b000, 1'b1,
                              3'b100, 2'd2, 1'b0));

        bus.reqs_i = '0;
        bus.lock_i = '0;
        yumi_en    = 1'b0;
        reset_i    = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            bus.reqs_i = vecs[i].reqs;
            bus.lock_i = vecs[i].lock;
            yumi_en    = vecs[i].yumi;
            @(posedge clk_i);
            #1;
            chk_all(vecs[i].name, vecs[i].grants, vecs[i].tag, vecs[i].v, vecs[i].to);
        end

        // async reset mid-BUSY while 100 is granted
        #2;
        reset_i = 1'b1;
        #1;
        chk_all("async_rst", 3'b000, 2'd0, 1'b0, 1'b0);
        #1;
        reset_i    = 1'b0;
        bus.reqs_i = 3'b110;
        bus.lock_i = 3'b000;
        yumi_en    = 1'b1;
        @(posedge clk_i);
        #1;
        chk_all("post_rst", 3'b010, 2'd1, 1'b1, 1'b0);
        @(posedge clk_i);
        #1;
        chk_all("post_rst2", 3'b100, 2'd2, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
